// File: rtl/spart_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spart_driver_pkg : shared states, bus addresses and baud divisors  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package spart_driver_pkg;

  typedef enum logic [2:0] {
    ST_CFG_LO = 3'd0,
    ST_CFG_HI = 3'd1,
    ST_POLL   = 3'd2,
    ST_RX     = 3'd3,
    ST_TX     = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam logic [15:0] C_DIV_4800  = 16'h0516;
  localparam logic [15:0] C_DIV_9600  = 16'h028B;
  localparam logic [15:0] C_DIV_19200 = 16'h0145;
  localparam logic [15:0] C_DIV_38400 = 16'h00A2;

  function automatic logic [15:0] divisor_for(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'b00:   div = C_DIV_4800;
      2'b01:   div = C_DIV_9600;
      2'b10:   div = C_DIV_19200;
      default: div = C_DIV_38400;
    endcase
    return div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spart_driver_echo_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | echo_fifo : byte FIFO holding received bytes until echoed back     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module echo_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import spart_driver_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == C_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spart_driver : programs SPART baud divisor, then echoes RX to TX   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module spart_driver #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  output logic                   iocs,
  output logic                   iorw,
  output logic [1:0]             ioaddr,
  output logic [7:0]             databus_out,
  input  logic [7:0]             databus_in,
  output logic [$clog2(DEPTH):0] fifo_count
);
  import spart_driver_pkg::*;

  state_e      r_state;
  state_e      w_next;
  logic [1:0]  r_br_cfg;
  logic        r_last_rx;
  logic        r_cfg_dirty;
  logic [15:0] w_div;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_head;
  logic        w_rx_ok;
  logic        w_tx_ok;
  logic        w_cfg_chg;

  assign w_div     = divisor_for(r_br_cfg);
  assign w_rx_ok   = databus_in[1] & ~w_full;
  assign w_tx_ok   = databus_in[0] & ~w_empty;
  assign w_cfg_chg = (br_cfg != r_br_cfg);

  echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_state == ST_RX),
    .pop   (r_state == ST_TX),
    .din   (databus_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Bus outputs follow the state, but reset forces the idle pattern.
  always_comb begin
    iocs        = 1'b0;
    iorw        = 1'b1;
    ioaddr      = ADDR_STAT;
    databus_out = 8'h00;
    if (!rst) begin
      iocs = 1'b1;
      case (r_state)
        ST_CFG_LO: begin iorw = 1'b0; ioaddr = ADDR_DBL; databus_out = w_div[7:0];  end
        ST_CFG_HI: begin iorw = 1'b0; ioaddr = ADDR_DBH; databus_out = w_div[15:8]; end
        ST_RX:     begin ioaddr = ADDR_BUF; end
        ST_TX:     begin iorw = 1'b0; ioaddr = ADDR_BUF; databus_out = w_head; end
        default:   begin ioaddr = ADDR_STAT; end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CFG_LO: w_next = ST_CFG_HI;
      ST_CFG_HI: w_next = (r_cfg_dirty || w_cfg_chg) ? ST_CFG_LO : ST_POLL;
      ST_POLL: begin
        if (w_cfg_chg)              w_next = ST_CFG_LO;
        else if (w_rx_ok && w_tx_ok) w_next = r_last_rx ? ST_TX : ST_RX;
        else if (w_rx_ok)           w_next = ST_RX;
        else if (w_tx_ok)           w_next = ST_TX;
        else                        w_next = ST_POLL;
      end
      ST_RX, ST_TX: w_next = w_cfg_chg ? ST_CFG_LO : ST_POLL;
      default:      w_next = ST_CFG_LO;
    endcase
  end

  // br_cfg is captured on every edge that enters CFG_LO so both divisor bytes agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CFG_LO;
      r_br_cfg    <= br_cfg;
      r_last_rx   <= 1'b0;
      r_cfg_dirty <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_CFG_LO && r_state != ST_CFG_LO) r_br_cfg <= br_cfg;
      if (r_state == ST_CFG_LO && w_cfg_chg)            r_cfg_dirty <= 1'b1;
      else if (r_state == ST_CFG_HI)                    r_cfg_dirty <= 1'b0;
      if (w_next == ST_RX && r_state == ST_POLL)        r_last_rx <= 1'b1;
      else if (w_next == ST_TX && r_state == ST_POLL)   r_last_rx <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spart_driver : scoreboard bench with a behavioural SPART model  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_spart_driver;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_out;
  logic [7:0] databus_in;
  logic [2:0] fifo_count;

  logic       sp_rda = 1'b0;
  logic       sp_tbr = 1'b0;
  logic [7:0] sp_rx  = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;

  always #5 clk = ~clk;

  spart_driver #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_cfg      (br_cfg),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .databus_out (databus_out),
    .databus_in  (databus_in),
    .fifo_count  (fifo_count)
  );

  // SPART responds combinationally to reads of status and the RX buffer.
  always_comb begin
    databus_in = 8'h00;
    if (iocs && iorw) begin
      if (ioaddr == 2'b01)      databus_in = {6'b0, sp_rda, sp_tbr};
      else if (ioaddr == 2'b00) databus_in = sp_rx;
    end
  end

  always @(negedge clk) begin
    if (rst || !iocs) begin
      checks++;
      if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b01 || databus_out !== 8'h00) begin
        errors++;
        $display("FAIL idle_bus: got cs=%b rw=%b addr=%b data=%h want cs=0 rw=1 addr=01 data=00",
                 iocs, iorw, ioaddr, databus_out);
      end
    end else begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access: got rw=%b addr=%b data=%h want none", iorw, ioaddr, databus_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (iorw !== mon_e.rw || ioaddr !== mon_e.addr || (!mon_e.rw && databus_out !== mon_e.data)) begin
          errors++;
          $display("FAIL bus_access @%0t: got rw=%b addr=%b data=%h want rw=%b addr=%b data=%h",
                   $time, iorw, ioaddr, databus_out, mon_e.rw, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic cyc(input logic rw, input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back(acc_t'{rw, a, d});
    @(posedge clk);
    #1;
  endtask

  task automatic poll();
    cyc(1'b1, 2'b01, 8'h00);
  endtask

  task automatic rx_read();
    cyc(1'b1, 2'b00, 8'h00);
  endtask

  task automatic chk_count(input int want, input string name);
    checks++;
    if (fifo_count !== 3'(want)) begin
      errors++;
      $display("FAIL %s: got fifo_count=%0d want %0d", name, fifo_count, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_count(0, "reset_count");
    rst = 1'b0;
    cyc(1'b0, 2'b10, 8'h8B);
    cyc(1'b0, 2'b11, 8'h02);
    poll();

    // Single byte echo
    sp_rda = 1'b1; sp_tbr = 1'b0; sp_rx = 8'h41;
    poll(); rx_read();
    chk_count(1, "rx_push");
    sp_rda = 1'b0; sp_tbr = 1'b1;
    poll(); cyc(1'b0, 2'b00, 8'h41);
    chk_count(0, "tx_pop");

    // Fill to full; further polls must not read RX
    sp_rda = 1'b1; sp_tbr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sp_rx = 8'hA1 + 8'(i);
      poll(); rx_read();
    end
    chk_count(4, "fill");
    poll(); poll();
    chk_count(4, "full_hold");

    // Alternation with both rda and tbr asserted
    sp_rda = 1'b0; sp_tbr = 1'b1;
    poll(); cyc(1'b0, 2'b00, 8'hA1);
    chk_count(3, "drain_one");
    sp_rda = 1'b1; sp_rx = 8'hB1;
    poll(); rx_read();
    poll(); cyc(1'b0, 2'b00, 8'hA2);
    sp_rx = 8'hB2;
    poll(); rx_read();
    poll(); cyc(1'b0, 2'b00, 8'hA3);
    chk_count(3, "alternate");

    // Baud change with two bytes held
    sp_rda = 1'b0;
    poll(); cyc(1'b0, 2'b00, 8'hA4);
    chk_count(2, "pre_baud");
    sp_tbr = 1'b0;
    br_cfg = 2'b11;
    poll();
    cyc(1'b0, 2'b10, 8'hA2);
    cyc(1'b0, 2'b11, 8'h00);
    poll();
    chk_count(2, "baud_keep");

    // Change while configuring restarts after CFG_HI
    br_cfg = 2'b10;
    poll();
    br_cfg = 2'b01;
    cyc(1'b0, 2'b10, 8'h45);
    cyc(1'b0, 2'b11, 8'h01);
    cyc(1'b0, 2'b10, 8'h8B);
    cyc(1'b0, 2'b11, 8'h02);
    poll();
    chk_count(2, "cfg_restart");

    // FIFO order preserved across the reconfiguration
    sp_tbr = 1'b1;
    poll(); cyc(1'b0, 2'b00, 8'hB1);
    poll(); cyc(1'b0, 2'b00, 8'hB2);
    chk_count(0, "drained");
    poll();

    // Reset during TX with three bytes held
    sp_tbr = 1'b0; sp_rda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sp_rx = 8'hC1 + 8'(i);
      poll(); rx_read();
    end
    chk_count(3, "refill");
    sp_rda = 1'b0; sp_tbr = 1'b1;
    poll();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_count(0, "reset_flush");
    br_cfg = 2'b10;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b0, 2'b10, 8'h45);
    cyc(1'b0, 2'b11, 8'h01);
    poll(); poll();
    chk_count(0, "post_reset");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_access: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
